// File: rtl/ariane_pkg.sv
// Shared types for the commit stage: scoreboard entry layout, functional-unit
// and operation encodings, exception causes and the commit FSM state.
package ariane_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 64;
  localparam int unsigned CSR_TIMEOUT_DEFAULT = 16;

  localparam logic [XLEN-1:0] INSTR_ADDR_MISALIGNED = 64'd0;
  localparam logic [XLEN-1:0] ILLEGAL_INSTR         = 64'd2;
  localparam logic [XLEN-1:0] LD_ACCESS_FAULT       = 64'd5;
  localparam logic [XLEN-1:0] ST_ACCESS_FAULT       = 64'd7;

  typedef enum logic [1:0] {
    IDLE,
    STORE_WAIT,
    CSR_WAIT,
    EXC
  } commit_state_e;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR,
    FPU
  } fu_t;

  typedef enum logic [7:0] {
    ADD,
    SUB,
    ANDL,
    ORL,
    XORL,
    LD,
    SD,
    FLD,
    FSD,
    FADD,
    FMUL,
    FMV_F2X,
    FMV_X2F,
    CSR_WRITE,
    CSR_READ,
    CSR_SET,
    CSR_CLEAR
  } fu_op;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_t             fu;
    fu_op            op;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            valid;
    exception_t      ex;
  } scoreboard_entry_t;

  // Operations whose destination lives in the floating-point register file.
  function automatic logic is_rd_fpr(input fu_op op);
    case (op)
      FLD, FADD, FMUL, FMV_X2F: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/commit_csr_timer.sv
// Loadable down-counter that saturates at zero; expired_o flags a zero count.
module commit_csr_timer
  import ariane_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/commit_retire_unit.sv
// Single-port commit stage: retires the scoreboard head via regfile write,
// store release, CSR handshake or exception raise with flush request.
module commit_retire_unit
  import ariane_pkg::*;
#(
  parameter int unsigned INSTRET_WIDTH = 64,
  parameter int unsigned CSR_TIMEOUT   = CSR_TIMEOUT_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     halt_i,
  input  logic                     flush_i,
  input  scoreboard_entry_t        commit_instr_i,
  input  logic                     commit_instr_valid_i,
  output logic                     commit_ack_o,
  output logic [4:0]               waddr_o,
  output logic [XLEN-1:0]          wdata_o,
  output logic                     we_gpr_o,
  output logic                     we_fpr_o,
  output logic                     commit_lsu_o,
  input  logic                     commit_lsu_ready_i,
  output logic                     csr_op_valid_o,
  output fu_op                     csr_op_o,
  output logic [XLEN-1:0]          csr_wdata_o,
  input  logic                     csr_done_i,
  input  logic [XLEN-1:0]          csr_rdata_i,
  input  logic                     csr_exception_i,
  output logic                     exception_valid_o,
  output logic [XLEN-1:0]          exception_cause_o,
  output logic [XLEN-1:0]          exception_tval_o,
  output logic [VLEN-1:0]          exception_pc_o,
  output logic                     flush_req_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  localparam int unsigned      TIMER_W    = $clog2(CSR_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(CSR_TIMEOUT - 1);

  commit_state_e            state_q, state_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  logic                     csr_op_valid_q, csr_op_valid_d;
  fu_op                     csr_op_q, csr_op_d;
  logic [XLEN-1:0]          csr_wdata_q, csr_wdata_d;

  logic            retireable;
  logic            timer_load, timer_en, timer_expired;
  logic            write_rd;
  logic [XLEN-1:0] write_data;
  logic            raise_exc;
  logic [XLEN-1:0] exc_cause, exc_tval;

  assign retireable = commit_instr_valid_i & commit_instr_i.valid;

  commit_csr_timer #(
    .WIDTH(TIMER_W)
  ) u_csr_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (TIMER_LOAD),
    .en_i       (timer_en),
    .expired_o  (timer_expired)
  );

  // NOTE: every signal written here gets a default first so no path leaves
  // one unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d           = state_q;
    instret_d         = instret_q;
    csr_op_valid_d    = 1'b0;
    csr_op_d          = csr_op_q;
    csr_wdata_d       = csr_wdata_q;
    timer_load        = 1'b0;
    timer_en          = 1'b0;
    write_rd          = 1'b0;
    write_data        = '0;
    raise_exc         = 1'b0;
    exc_cause         = '0;
    exc_tval          = '0;
    commit_ack_o      = 1'b0;
    waddr_o           = '0;
    wdata_o           = '0;
    we_gpr_o          = 1'b0;
    we_fpr_o          = 1'b0;
    commit_lsu_o      = 1'b0;
    exception_valid_o = 1'b0;
    exception_cause_o = '0;
    exception_tval_o  = '0;
    exception_pc_o    = '0;
    flush_req_o       = 1'b0;

    // Outputs are combinational, so they are held quiet while reset is high.
    if (!rst_i) begin
      if (flush_i) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!halt_i && retireable) begin
              if (commit_instr_i.ex.valid) begin
                raise_exc = 1'b1;
                exc_cause = commit_instr_i.ex.cause;
                exc_tval  = commit_instr_i.ex.tval;
              end else if (commit_instr_i.fu == STORE) begin
                commit_lsu_o = 1'b1;
                if (commit_lsu_ready_i) commit_ack_o = 1'b1;
                else                    state_d      = STORE_WAIT;
              end else if (commit_instr_i.fu == CSR) begin
                csr_op_valid_d = 1'b1;
                csr_op_d       = commit_instr_i.op;
                csr_wdata_d    = commit_instr_i.result;
                timer_load     = 1'b1;
                state_d        = CSR_WAIT;
              end else begin
                commit_ack_o = 1'b1;
                write_rd     = 1'b1;
                write_data   = commit_instr_i.result;
              end
            end
          end
          STORE_WAIT: begin
            if (retireable) begin
              commit_lsu_o = 1'b1;
              if (commit_lsu_ready_i) begin
                commit_ack_o = 1'b1;
                state_d      = IDLE;
              end
            end
          end
          CSR_WAIT: begin
            if (retireable) begin
              if (csr_done_i && !csr_exception_i) begin
                commit_ack_o = 1'b1;
                write_rd     = 1'b1;
                write_data   = csr_rdata_i;
                state_d      = IDLE;
              end else if (csr_done_i || timer_expired) begin
                raise_exc = 1'b1;
                exc_cause = ILLEGAL_INSTR;
              end else begin
                timer_en = 1'b1;
              end
            end
          end
          EXC:     state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end

    if (raise_exc) begin
      exception_valid_o = 1'b1;
      exception_cause_o = exc_cause;
      exception_tval_o  = exc_tval;
      exception_pc_o    = commit_instr_i.pc;
      flush_req_o       = 1'b1;
      commit_ack_o      = 1'b1;
      state_d           = EXC;
    end else if (commit_ack_o) begin
      instret_d = instret_q + INSTRET_WIDTH'(1);
    end

    if (write_rd) begin
      waddr_o  = commit_instr_i.rd;
      wdata_o  = write_data;
      we_fpr_o = is_rd_fpr(commit_instr_i.op);
      we_gpr_o = !is_rd_fpr(commit_instr_i.op) && (commit_instr_i.rd != 5'd0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      instret_q      <= '0;
      csr_op_valid_q <= 1'b0;
      csr_op_q       <= ADD;
      csr_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      instret_q      <= instret_d;
      csr_op_valid_q <= csr_op_valid_d;
      csr_op_q       <= csr_op_d;
      csr_wdata_q    <= csr_wdata_d;
    end
  end

  assign csr_op_valid_o = csr_op_valid_q & ~flush_i;
  assign csr_op_o       = csr_op_q;
  assign csr_wdata_o    = csr_wdata_q;
  assign instret_o      = instret_q;

endmodule
